// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Multicycle load/store port between the datapath and the
//               memory bus. Latches one request and checks that it is legal.
//               It then runs a single read or write under the mem_resp
//               handshake, and drives aligned store data and byte enables.
//               Loads return a sign- or zero-extended result.
// Ports       : clk, rst (async, active-high)
//               start, we, funct3, addr, wdata     - request from control
//               mem_resp, mem_rdata                 - memory completion
//               mem_read, mem_write, mem_address,
//               mem_wdata, mem_byte_enable          - memory request
//               busy, done, fault, rdata            - status / load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FIN    = 2'd2
  } state_t;

  // Last ACCESS cycle index before a timeout abort (unused when TIMEOUT == 0)
  localparam logic [31:0] C_TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timer_q, timer_d;
  logic        fault_q, fault_d;

  logic        w_legal;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_ext;
  logic        w_timeout;

  // Legality is evaluated on the incoming request. It is the same value that
  // gets latched on start.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~addr[0];
      3'b010:  w_legal = (addr[1:0] == 2'b00);
      3'b100:  w_legal = ~we;
      3'b101:  w_legal = ~we & ~addr[0];
      default: w_legal = 1'b0;
    endcase
  end

  // Select the addressed lane from the returned word and extend it
  always_comb begin
    w_lane_b = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: w_lane_b = mem_rdata[7:0];
      2'd1: w_lane_b = mem_rdata[15:8];
      2'd2: w_lane_b = mem_rdata[23:16];
      2'd3: w_lane_b = mem_rdata[31:24];
      default: w_lane_b = mem_rdata[7:0];
    endcase
    w_lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
      3'b001:  w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
      3'b100:  w_load_ext = {24'h000000, w_lane_b};
      3'b101:  w_load_ext = {16'h0000, w_lane_h};
      default: w_load_ext = mem_rdata;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (timer_q == C_TO_LAST);

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          timer_d = 32'd0;
          fault_d = ~w_legal;
          state_d = w_legal ? S_ACCESS : S_FIN;
        end
      end
      S_ACCESS: begin
        timer_d = timer_q + 32'd1;
        // A response in the timeout cycle still completes the access normally
        if (mem_resp) begin
          if (!we_q) begin
            rdata_d = w_load_ext;
          end
          state_d = S_FIN;
        end else if (w_timeout) begin
          fault_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      timer_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

  // Requests are decoded from the state register. An async reset therefore
  // drops them at once.
  always_comb begin
    mem_read        = (state_q == S_ACCESS) & ~we_q;
    mem_write       = (state_q == S_ACCESS) & we_q;
    mem_address     = {addr_q[31:2], 2'b00};
    mem_wdata       = wdata_q << {addr_q[1:0], 3'b000};
    mem_byte_enable = 4'b0000;
    if ((state_q == S_ACCESS) && we_q) begin
      case (f3_q[1:0])
        2'b00:   mem_byte_enable = 4'b0001 << addr_q[1:0];
        2'b01:   mem_byte_enable = 4'b0011 << addr_q[1:0];
        default: mem_byte_enable = 4'b1111;
      endcase
    end
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_FIN);
    fault = (state_q == S_FIN) & fault_q;
    rdata = rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. It pushes the
//               expected completion when each request is issued, then pops
//               and compares it when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, we, mem_resp;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;

  logic        mem_read, mem_write, busy, done, fault;
  logic [31:0] mem_address, mem_wdata, rdata;
  logic [3:0]  mem_byte_enable;

  logic        inf_read, inf_write, inf_busy, inf_done, inf_fault;
  logic [31:0] inf_address, inf_wdata, inf_rdata;
  logic [3:0]  inf_be;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata)
  );

  // Same stimulus, no timeout: must keep waiting where dut aborts
  mem_access_unit #(.TIMEOUT(0)) dut_inf (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(inf_read), .mem_write(inf_write), .mem_address(inf_address),
    .mem_wdata(inf_wdata), .mem_byte_enable(inf_be),
    .busy(inf_busy), .done(inf_done), .fault(inf_fault), .rdata(inf_rdata)
  );

  // Issue one request; answer after resp_at request cycles (0 = never)
  task automatic run_op(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] md, input int resp_at,
                        input logic e_fault, input logic [31:0] e_rdata,
                        input int e_req, input logic [31:0] e_wd,
                        input logic [3:0] e_be);
    int   req;
    bit   seen;
    exp_t e;
    exp_t got;
    @(negedge clk);
    start = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    e.fault = e_fault; e.rdata = e_rdata;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    req = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        total++;
        if ((mem_read | mem_write) !== 1'b0) begin
          bad++; $display("FAIL %s req_in_done: got %b want 0", name, mem_read | mem_write);
        end
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL %s scoreboard_empty: got done want none", name);
        end else begin
          got = exp_q.pop_front();
          total++;
          if (fault !== got.fault) begin
            bad++; $display("FAIL %s fault: got %b want %b", name, fault, got.fault);
          end
          total++;
          if (rdata !== got.rdata) begin
            bad++; $display("FAIL %s rdata: got %h want %h", name, rdata, got.rdata);
          end
        end
      end else if (mem_read | mem_write) begin
        req++;
        if (req == 1) begin
          total++;
          if ({mem_read, mem_write} !== {~w, w}) begin
            bad++; $display("FAIL %s rw: got %b%b want %b%b", name, mem_read, mem_write, ~w, w);
          end
          total++;
          if (mem_address !== (a & 32'hFFFF_FFFC)) begin
            bad++; $display("FAIL %s mem_address: got %h want %h", name, mem_address, a & 32'hFFFF_FFFC);
          end
          total++;
          if (mem_byte_enable !== e_be) begin
            bad++; $display("FAIL %s byte_enable: got %b want %b", name, mem_byte_enable, e_be);
          end
          if (w) begin
            total++;
            if (mem_wdata !== e_wd) begin
              bad++; $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, e_wd);
            end
          end
        end
        if (req == resp_at) begin
          mem_resp = 1'b1; mem_rdata = md;
        end
      end
      if (!seen) begin
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = $urandom;
      end
    end
    if (!seen) begin
      total++; bad++; $display("FAIL %s done_timeout: got no done want done", name);
    end
    total++;
    if (req != e_req) begin
      bad++; $display("FAIL %s request_cycles: got %0d want %0d", name, req, e_req);
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'd0;
    wdata = 32'd0; mem_resp = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_read, mem_write, busy, done, fault, mem_byte_enable} !== 9'd0 ||
        mem_address !== 32'd0 || mem_wdata !== 32'd0 || rdata !== 32'd0) begin
      bad++; $display("FAIL reset_state: got r%b w%b b%b d%b f%b be%b a%h wd%h rd%h want all 0",
                      mem_read, mem_write, busy, done, fault, mem_byte_enable,
                      mem_address, mem_wdata, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    run_op("lw",     1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 3, 32'h0, 4'b0000);
    run_op("lb",     1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b0, 32'hFFFFFF80, 1, 32'h0, 4'b0000);
    run_op("lbu",    1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2, 1'b0, 32'h00000080, 2, 32'h0, 4'b0000);
    run_op("lhu",    1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1, 1'b0, 32'h00008011, 1, 32'h0, 4'b0000);
    run_op("lh",     1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, 1'b0, 32'hFFFF8011, 1, 32'h0, 4'b0000);
    run_op("lb0",    1'b0, 3'b000, 32'h100, 32'h0, 32'h80112233, 1, 1'b0, 32'h00000033, 1, 32'h0, 4'b0000);
  endtask

  task automatic test_store();
    run_op("sh",     1'b1, 3'b001, 32'h206, 32'h0000ABCD, 32'h0, 2, 1'b0, 32'h33, 2, 32'hABCD0000, 4'b1100);
    run_op("sb",     1'b1, 3'b000, 32'h201, 32'h000000EF, 32'h0, 1, 1'b0, 32'h33, 1, 32'h0000EF00, 4'b0010);
    run_op("sw",     1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0, 1, 1'b0, 32'h33, 1, 32'h12345678, 4'b1111);
  endtask

  task automatic test_illegal();
    run_op("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1'b1, 32'h33, 0, 32'h0, 4'b0000);
    run_op("st_011", 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b1, 32'h33, 0, 32'h0, 4'b0000);
    run_op("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1, 1'b1, 32'h33, 0, 32'h0, 4'b0000);
    run_op("sbu",    1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 1'b1, 32'h33, 0, 32'h0, 4'b0000);
  endtask

  task automatic test_resp_idle();
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp = 1'b0;
    total++;
    if ({done, busy} !== 2'b00 || rdata !== 32'h33) begin
      bad++; $display("FAIL resp_idle: got done=%b busy=%b rdata=%h want 0 0 00000033", done, busy, rdata);
    end
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1'b1, 32'h33, 4, 32'h0, 4'b0000);
    total++;
    if ({inf_busy, inf_read, inf_done} !== 3'b110) begin
      bad++; $display("FAIL no_timeout: got busy=%b read=%b done=%b want 1 1 0", inf_busy, inf_read, inf_done);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_busy_start();
    int   req;
    int   extra;
    bit   seen;
    exp_t e;
    exp_t got;
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h500;
    e.fault = 1'b0; e.rdata = 32'h0BADF00D;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; we = 1'b1; addr = 32'h600;
    req = 0; seen = 1'b0; extra = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        got = exp_q.pop_front();
        total++;
        if (rdata !== got.rdata || fault !== got.fault) begin
          bad++; $display("FAIL busy_start_result: got %h/%b want %h/%b", rdata, fault, got.rdata, got.fault);
        end
      end else if (mem_read) begin
        req++;
        total++;
        if (mem_address !== 32'h500) begin
          bad++; $display("FAIL busy_start_addr: got %h want 00000500", mem_address);
        end
        if (req == 3) begin
          mem_resp = 1'b1; mem_rdata = 32'h0BADF00D;
        end
      end
      if (!seen) begin
        @(negedge clk);
        start = 1'b0; mem_resp = 1'b0;
      end
    end
    if (!seen) begin
      total++; bad++; $display("FAIL busy_start_done: got no done want done");
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_read | mem_write | done) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL busy_start_queued: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_lw",  1'b0, 3'b010, 32'h800, 32'h0, 32'h11223344, 1, 1'b0, 32'h11223344, 1, 32'h0, 4'b0000);
    run_op("b2b_sw",  1'b1, 3'b010, 32'h804, 32'hCAFEBABE, 32'h0, 1, 1'b0, 32'h11223344, 1, 32'hCAFEBABE, 4'b1111);
    run_op("b2b_lhu", 1'b0, 3'b101, 32'h806, 32'h0, 32'hF00D1234, 2, 1'b0, 32'h0000F00D, 2, 32'h0, 4'b0000);
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h700;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre: got read=%b want 1", mem_read);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_read, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset_mid: got read=%b busy=%b done=%b want 0 0 0", mem_read, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done | mem_read) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL reset_mid_after: got %0d active cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_illegal();
    test_resp_idle();
    test_timeout();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
